// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 serial back-end: frame geometry, step
// decode and the {seg, sel} MSB-first bit-order convention.
package hc595_pkg;

   localparam int FRAME_BITS  = 16;
   localparam int FRAME_STEPS = 34;
   localparam int STEP_W      = $clog2(FRAME_STEPS);
   localparam int BIT_W       = $clog2(FRAME_BITS);

   typedef logic [7:0]            byte_t;
   typedef logic [FRAME_BITS-1:0] frame_t;
   typedef logic [STEP_W-1:0]     step_t;

   typedef enum logic [1:0] {
      PH_SHIFT,   // present next data bit, shift clock low
      PH_CLOCK,   // shift clock high
      PH_LATCH,   // storage clock high
      PH_DONE     // storage clock low, reload shadow
   } phase_e;

   // seg goes out first so it ends up in the far (second) 595.
   function automatic frame_t pack_frame(input byte_t seg, input byte_t sel);
      return {seg, sel};
   endfunction

   function automatic phase_e step_phase(input step_t s);
      if (s == step_t'(FRAME_STEPS - 2)) return PH_LATCH;
      if (s == step_t'(FRAME_STEPS - 1)) return PH_DONE;
      if (s[0])                          return PH_CLOCK;
      return PH_SHIFT;
   endfunction

endpackage

// File: rtl/hc595_if.sv
// Scanner-side data plus board-side 595 pins for the serial back-end.
interface hc595_if;
   import hc595_pkg::*;

   logic  en;
   byte_t sel;
   byte_t seg;
   logic  ds;
   logic  sh_cp;
   logic  st_cp;
   logic  frame_done;

   modport master (output en, sel, seg, input ds, sh_cp, st_cp, frame_done);
   modport slave  (input en, sel, seg, output ds, sh_cp, st_cp, frame_done);

endinterface

// File: rtl/hc595_driver_tick_gen.sv
// Clock-enable divider: one-cycle tick every HALF clocks, held in reset by clr_i.
module tick_gen #(
   parameter int HALF = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0] div_cnt_q;
   logic          term;

   assign term   = (div_cnt_q == CW'(HALF - 1));
   assign tick_o = term && !clr_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          div_cnt_q <= '0;
      else if (clr_i || term) div_cnt_q <= '0;
      else                   div_cnt_q <= div_cnt_q + CW'(1);
   end

endmodule

// File: rtl/hc595_driver.sv
// Streams {seg, sel} as back-to-back 16-bit frames into two cascaded 74HC595s.
// A frame is 34 ticks: 16 low/high shift-clock pairs, then a latch pulse.
module hc595_driver
   import hc595_pkg::*;
#(
   parameter int SCLK_HALF = 2
) (
   input  logic   clk,
   input  logic   reset_n,
   hc595_if.slave bus
);

   logic             tick;
   step_t            step_q;
   frame_t           shadow_q;
   logic             ds_q, sh_cp_q, st_cp_q, done_q;
   logic [BIT_W-1:0] bit_idx;

   tick_gen #(.HALF(SCLK_HALF)) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (!bus.en),
      .tick_o  (tick)
   );

   // Shift steps are 0..31, so step/2 is the bit number within the frame.
   assign bit_idx = step_q[BIT_W:1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_q   <= '0;
         shadow_q <= '0;
         ds_q     <= 1'b0;
         sh_cp_q  <= 1'b0;
         st_cp_q  <= 1'b0;
         done_q   <= 1'b0;
      end else if (!bus.en) begin
         // Idle: keep tracking the inputs so the first frame uses fresh data.
         step_q   <= '0;
         shadow_q <= pack_frame(bus.seg, bus.sel);
         ds_q     <= 1'b0;
         sh_cp_q  <= 1'b0;
         st_cp_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (tick) begin
            unique case (step_phase(step_q))
               PH_SHIFT: begin
                  ds_q    <= shadow_q[BIT_W'(FRAME_BITS - 1) - bit_idx];
                  sh_cp_q <= 1'b0;
               end
               PH_CLOCK: sh_cp_q <= 1'b1;
               PH_LATCH: begin
                  sh_cp_q <= 1'b0;
                  st_cp_q <= 1'b1;
               end
               PH_DONE: begin
                  st_cp_q  <= 1'b0;
                  done_q   <= 1'b1;
                  shadow_q <= pack_frame(bus.seg, bus.sel);
               end
            endcase
            step_q <= (step_q == step_t'(FRAME_STEPS - 1)) ? '0 : step_q + step_t'(1);
         end
      end
   end

   assign bus.ds         = ds_q;
   assign bus.sh_cp      = sh_cp_q;
   assign bus.st_cp      = st_cp_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_hc595_driver.sv
// Directed bench for hc595_driver: SCLK_HALF=1 instance with a 595 model,
// plus a default SCLK_HALF=2 instance for phase timing.
module tb_hc595_driver;

   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   hc595_if if1 ();
   hc595_if if2 ();

   hc595_driver #(.SCLK_HALF(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
   hc595_driver                  dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

   // Two cascaded 595s seen as one 16-bit shift register plus output latch.
   logic [15:0] sr1, lat1;
   always @(posedge if1.sh_cp) sr1 <= {sr1[14:0], if1.ds};
   always @(posedge if1.st_cp) lat1 <= sr1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Collect ds at each sh_cp rise until frame_done; optionally change seg after bit chg_bit.
   task automatic capture1(input int chg_bit, input logic [7:0] chg_seg,
                           output logic [15:0] w, output int cycles,
                           output int st_hi, output bit ok);
      int   n;
      bit   done;
      logic prev;
      w = '0; n = 0; cycles = 0; st_hi = 0; done = 0;
      prev = if1.sh_cp;
      while (!done && cycles < 200) begin
         @(negedge clk);
         cycles++;
         if (!prev && if1.sh_cp) begin
            w = {w[14:0], if1.ds};
            n++;
            if (n == chg_bit) if1.seg = chg_seg;
         end
         prev = if1.sh_cp;
         if (if1.st_cp) st_hi++;
         if (if1.frame_done) done = 1;
      end
      ok = done && (n == 16);
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      if1.en = 1'b0; if1.seg = 8'hC0; if1.sel = 8'h01;
      if2.en = 1'b0; if2.seg = 8'hC0; if2.sel = 8'h01;
      #1 reset_n = 1'b0;
      @(negedge clk); @(negedge clk);
      tests++;
      if ({if1.ds, if1.sh_cp, if1.st_cp, if1.frame_done} !== 4'b0) begin
         fails++; $display("FAIL reset_outs1: got %b want 0000",
                           {if1.ds, if1.sh_cp, if1.st_cp, if1.frame_done});
      end
      tests++;
      if ({if2.ds, if2.sh_cp, if2.st_cp, if2.frame_done} !== 4'b0) begin
         fails++; $display("FAIL reset_outs2: got %b want 0000",
                           {if2.ds, if2.sh_cp, if2.st_cp, if2.frame_done});
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({if1.ds, if1.sh_cp, if1.st_cp, if1.frame_done} !== 4'b0) begin
         fails++; $display("FAIL idle_outs1: got %b want 0000",
                           {if1.ds, if1.sh_cp, if1.st_cp, if1.frame_done});
      end
   endtask

   task automatic test_basic();
      logic [15:0] w; int cyc, sth; bit ok;
      if1.en = 1'b1;
      capture1(-1, 8'h00, w, cyc, sth, ok);
      tests++;
      if (!ok || w !== 16'hC001) begin
         fails++; $display("FAIL basic_word: got %h ok=%0d want c001", w, ok);
      end
      tests++;
      if (sth !== 1) begin
         fails++; $display("FAIL basic_st_width: got %0d want 1", sth);
      end
      tests++;
      if (lat1 !== 16'hC001) begin
         fails++; $display("FAIL basic_latch: got %h want c001", lat1);
      end
      capture1(-1, 8'h00, w, cyc, sth, ok);
      tests++;
      if (!ok || cyc !== 34 || w !== 16'hC001) begin
         fails++; $display("FAIL basic_period: got %0d cycles word %h want 34 c001", cyc, w);
      end
   endtask

   task automatic test_timing_half2();
      int   cyc, hi_run, min_hi, max_hi, since, min_setup, rises, sth;
      bit   done;
      logic prev_sh, prev_ds;
      if2.en = 1'b1;
      done = 0; cyc = 0;
      while (!done && cyc < 300) begin
         @(negedge clk); cyc++;
         if (if2.frame_done) done = 1;
      end
      tests++;
      if (!done) begin
         fails++; $display("FAIL h2_first_done: got timeout want frame_done");
      end
      done = 0; cyc = 0; hi_run = 0; min_hi = 99; max_hi = 0;
      since = 100; min_setup = 100; rises = 0; sth = 0;
      prev_sh = if2.sh_cp; prev_ds = if2.ds;
      while (!done && cyc < 300) begin
         @(negedge clk); cyc++;
         if (if2.ds !== prev_ds) since = 0; else since++;
         prev_ds = if2.ds;
         if (if2.sh_cp) hi_run++;
         if (!prev_sh && if2.sh_cp) begin
            rises++;
            if (since < min_setup) min_setup = since;
         end
         if (prev_sh && !if2.sh_cp) begin
            if (hi_run < min_hi) min_hi = hi_run;
            if (hi_run > max_hi) max_hi = hi_run;
            hi_run = 0;
         end
         prev_sh = if2.sh_cp;
         if (if2.st_cp) sth++;
         if (if2.frame_done) done = 1;
      end
      tests++;
      if (!done || cyc !== 68) begin
         fails++; $display("FAIL h2_period: got %0d done=%0d want 68", cyc, done);
      end
      tests++;
      if (min_hi !== 2 || max_hi !== 2 || rises !== 16) begin
         fails++; $display("FAIL h2_high_phase: got min %0d max %0d rises %0d want 2 2 16",
                           min_hi, max_hi, rises);
      end
      tests++;
      if (min_setup < 2) begin
         fails++; $display("FAIL h2_ds_setup: got %0d want >=2", min_setup);
      end
      tests++;
      if (sth !== 2) begin
         fails++; $display("FAIL h2_st_width: got %0d want 2", sth);
      end
   endtask

   task automatic test_midframe_change();
      logic [15:0] w; int cyc, sth; bit ok;
      capture1(5, 8'hF9, w, cyc, sth, ok);
      tests++;
      if (!ok || w !== 16'hC001) begin
         fails++; $display("FAIL mid_current: got %h ok=%0d want c001", w, ok);
      end
      capture1(-1, 8'h00, w, cyc, sth, ok);
      tests++;
      if (!ok || w !== 16'hF901) begin
         fails++; $display("FAIL mid_next: got %h ok=%0d want f901", w, ok);
      end
      tests++;
      if (lat1 !== 16'hF901) begin
         fails++; $display("FAIL mid_latch: got %h want f901", lat1);
      end
   endtask

   task automatic test_en_drop();
      logic [15:0] w, lat_before; int cyc, sth; bit ok, st_seen;
      repeat (20) @(negedge clk);
      lat_before = lat1;
      if1.en = 1'b0;
      @(negedge clk);
      tests++;
      if ({if1.ds, if1.sh_cp, if1.st_cp, if1.frame_done} !== 4'b0) begin
         fails++; $display("FAIL drop_outs: got %b want 0000",
                           {if1.ds, if1.sh_cp, if1.st_cp, if1.frame_done});
      end
      st_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (if1.st_cp) st_seen = 1;
      end
      tests++;
      if (st_seen || lat1 !== lat_before) begin
         fails++; $display("FAIL drop_no_latch: got st=%0d lat %h want 0 %h",
                           st_seen, lat1, lat_before);
      end
      if1.sel = 8'h80;
      @(negedge clk);
      if1.en = 1'b1;
      capture1(-1, 8'h00, w, cyc, sth, ok);
      tests++;
      if (!ok || w !== 16'hF980 || cyc !== 34) begin
         fails++; $display("FAIL drop_restart: got %h cyc %0d want f980 34", w, cyc);
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] w; int cyc, sth; bit ok;
      repeat (32) @(negedge clk);
      tests++;
      if (if1.sh_cp !== 1'b1) begin
         fails++; $display("FAIL areset_pre: got sh_cp %b want 1", if1.sh_cp);
      end
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if ({if1.ds, if1.sh_cp, if1.st_cp, if1.frame_done,
           if2.ds, if2.sh_cp, if2.st_cp, if2.frame_done} !== 8'b0) begin
         fails++; $display("FAIL areset_outs: got %b want 00000000",
                           {if1.ds, if1.sh_cp, if1.st_cp, if1.frame_done,
                            if2.ds, if2.sh_cp, if2.st_cp, if2.frame_done});
      end
      @(negedge clk);
      reset_n = 1'b1;
      capture1(-1, 8'h00, w, cyc, sth, ok);
      tests++;
      if (!ok || w !== 16'h0000 || cyc !== 34) begin
         fails++; $display("FAIL areset_first: got %h cyc %0d want 0000 34", w, cyc);
      end
      capture1(-1, 8'h00, w, cyc, sth, ok);
      tests++;
      if (!ok || w !== 16'hF980) begin
         fails++; $display("FAIL areset_second: got %h want f980", w);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w, exp_w, nxt; int cyc, sth; bit ok;
      exp_w = {if1.seg, if1.sel};
      for (int i = 0; i < 100; i++) begin
         nxt = 16'($urandom);
         if1.seg = nxt[15:8];
         if1.sel = nxt[7:0];
         capture1(-1, 8'h00, w, cyc, sth, ok);
         tests++;
         if (!ok || w !== exp_w || lat1 !== exp_w) begin
            fails++; $display("FAIL b2b_frame%0d: got ds %h latch %h want %h",
                              i, w, lat1, exp_w);
         end
         exp_w = nxt;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timing_half2();
      test_midframe_change();
      test_en_drop();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
